// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: one command in, one bus cycle out,
// one response back (read data, err or timeout) over valid/ready handshakes.
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int TIMEOUT    = 16,
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // command port
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  // response port
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  // Wishbone master
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int CNT_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_we;
  logic                  r_cyc;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_dat;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  logic w_term;
  logic w_timeout;

  assign w_term    = ack_i | err_i;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_adr         <= '0;
      r_dat         <= '0;
      r_sel         <= '0;
      r_we          <= 1'b0;
      r_cyc         <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_adr   <= cmd_adr_i;
            r_dat   <= cmd_dat_i;
            r_sel   <= cmd_sel_i;
            r_we    <= cmd_we_i;
            r_cyc   <= 1'b1;
            r_state <= ST_BUS;
          end
        end
        ST_BUS: begin
          r_cnt <= r_cnt + 1'b1;
          // A termination seen in the timeout cycle still counts as a termination.
          if (w_term || w_timeout) begin
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_rsp_dat     <= (ack_i && !err_i && !r_we) ? dat_i : '0;
            r_rsp_err     <= err_i;
            r_rsp_timeout <= !w_term;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (r_state == ST_IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
  assign sel_o         = r_sel;
  assign we_o          = r_we;
  assign cyc_o         = r_cyc;
  assign stb_o         = r_cyc;

endmodule
